// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between a master (or interconnect) and ahb_slave_mem.
// HREADY is the interconnect-level ready; it is driven from the master side.
interface ahb_slave_mem_if #(
    parameter int ADDR_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [1:0]        HTRANS;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [31:0]       HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic              HRESP;
    logic [31:0]       HRDATA;

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave in front of a word-organised SRAM (MEM_DEPTH x 32 bit).
// Pipelined address/data phases, little-endian byte lanes, two-cycle ERROR
// response. Optional feature macro AHB_WAIT_STATE_EN inserts WAIT_CYCLES
// HREADYOUT-low cycles in front of every OKAY data phase.
module ahb_slave_mem #(
    parameter int ADDR_W      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic          HCLK,
    input logic          HRESET,
    ahb_slave_mem_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int OFF_W = IDX_W + 2;
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(MEM_DEPTH * 4);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
`ifdef AHB_WAIT_STATE_EN
        , ST_WAIT
`endif
    } state_t;

    state_t             state;
    state_t             start_state;
    logic               hreadyout_q;
    logic               hresp_q;
    logic [OFF_W-1:0]   addr_q;
    logic               write_q;
    logic [1:0]         size_q;
    logic               err_q;
    logic               accept;
    logic               addr_err;
    logic [3:0]         lane_en;
    logic [IDX_W-1:0]   idx;
    logic [31:0]        mem [MEM_DEPTH];
`ifdef AHB_WAIT_STATE_EN
    logic [3:0]         wait_cnt;
`endif

    // Address-phase decode: acceptance, error classification, entry state
    always_comb begin
        accept   = bus.HSEL & bus.HREADY & bus.HTRANS[1];
        addr_err = ({1'b0, bus.HADDR} >= MEM_BYTES)
                 || (bus.HSIZE > 3'b010)
                 || ((bus.HSIZE == 3'b001) && bus.HADDR[0])
                 || ((bus.HSIZE == 3'b010) && (bus.HADDR[1:0] != 2'b00));
        start_state = ST_DATA;
`ifdef AHB_WAIT_STATE_EN
        if (WAIT_CYCLES != 0) start_state = ST_WAIT;
`endif
        // Error transfers never wait; they go straight to the ERROR response
        if (addr_err) start_state = ST_ERR1;
    end

    // Response FSM with registered HREADYOUT/HRESP and address-phase capture
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            err_q       <= 1'b0;
`ifdef AHB_WAIT_STATE_EN
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
`ifdef AHB_WAIT_STATE_EN
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state       <= ST_DATA;
                        hreadyout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
`endif
                // IDLE, DATA and ERR2 all sample a new address phase
                default: begin
                    if (accept) begin
                        addr_q      <= bus.HADDR[OFF_W-1:0];
                        write_q     <= bus.HWRITE;
                        size_q      <= bus.HSIZE[1:0];
                        err_q       <= addr_err;
                        state       <= start_state;
                        hreadyout_q <= (start_state == ST_DATA);
                        hresp_q     <= (start_state == ST_ERR1);
`ifdef AHB_WAIT_STATE_EN
                        wait_cnt    <= 4'(WAIT_CYCLES - 1);
`endif
                    end else begin
                        state       <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Byte-lane enables for the current data phase (little-endian)
    always_comb begin
        case (size_q)
            2'b00:   lane_en = 4'b0001 << addr_q[1:0];
            2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    assign idx = addr_q[OFF_W-1:2];

    // SRAM write port: commits on the edge that ends a write data phase
    always_ff @(posedge HCLK) begin
        if ((state == ST_DATA) && write_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem[idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
            end
        end
    end

    // Read data is driven only during a read data phase, zero otherwise
    assign bus.HRDATA    = ((state == ST_DATA) && !write_q) ? mem[idx] : 32'd0;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;

    // HBURST is deliberately ignored: every beat is decoded on its own
    logic unused_ok;
    assign unused_ok = ^{bus.HBURST, 4'(WAIT_CYCLES)};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench for ahb_slave_mem: directed scenarios plus randomized
// beats, all checked against a byte-addressed behavioural memory model.
module tb_ahb_slave_mem;

    localparam int WAIT_CYCLES = 2;
`ifdef AHB_WAIT_STATE_EN
    localparam int WAIT_EFF = WAIT_CYCLES;
`else
    localparam int WAIT_EFF = 0;
`endif

    typedef struct {
        bit          wr;
        bit          sel;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        logic [1:0]  trans;
    } beat_t;

    logic HCLK = 1'b0;
    logic HRESET;
    int   n_checks = 0;
    int   n_errors = 0;
    bit [7:0]    mb [1024];
    logic [31:0] rd_log [$];

    ahb_slave_mem_if #(.ADDR_W(32)) bus ();
    assign bus.HREADY = bus.HREADYOUT;

    ahb_slave_mem #(
        .ADDR_W(32), .MEM_DEPTH(256), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input bit wr, input logic [31:0] a, input logic [2:0] sz,
                                 input logic [31:0] d, input logic [1:0] tr, input bit sel);
        beat_t b;
        b.wr = wr; b.addr = a; b.size = sz; b.data = d; b.trans = tr; b.sel = sel;
        return b;
    endfunction

    function automatic bit model_err(input beat_t b);
        if (b.addr >= 32'd1024) return 1'b1;
        if (b.size > 3'd2) return 1'b1;
        return (b.addr % (32'd1 << b.size)) != 32'd0;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        base = int'(a) & ~3;
        return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
    endfunction

    task automatic model_write(input beat_t b);
        int a;
        for (int k = 0; k < (1 << b.size); k++) begin
            a = int'(b.addr) + k;
            mb[a] = b.data[8*(a%4) +: 8];
        end
    endtask

    task automatic drive_addr(input beat_t b);
        bus.HSEL   = b.sel;
        bus.HADDR  = b.addr;
        bus.HWRITE = b.wr;
        bus.HSIZE  = b.size;
        bus.HTRANS = b.trans;
        bus.HBURST = 3'b001;
    endtask

    task automatic drive_idle();
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
    endtask

    // Runs a pipelined sequence of beats; called and returns at posedge+1.
    task automatic run_beats(input string name, input beat_t q[$]);
        int    i = 0;
        int    ph = 0;
        int    guard = 0;
        int    limit;
        bit    pend = 0;
        bit    perr = 0;
        beat_t p;
        logic  er, eresp;
        logic [31:0] edata;
        limit = q.size() * (WAIT_EFF + 3) + 8;
        while ((i < q.size() || pend) && guard < limit) begin
            guard++;
            if (i < q.size()) drive_addr(q[i]); else drive_idle();
            bus.HWDATA = pend ? p.data : 32'h0;
            if (!pend) begin
                er = 1'b1; eresp = 1'b0; edata = 32'd0;
            end else if (perr) begin
                er = (ph != 0); eresp = 1'b1; edata = 32'd0;
            end else if (ph < WAIT_EFF) begin
                er = 1'b0; eresp = 1'b0; edata = 32'd0;
            end else begin
                er = 1'b1; eresp = 1'b0;
                edata = p.wr ? 32'd0 : model_word(p.addr);
            end
            check({name, ".rdy"},   {31'd0, bus.HREADYOUT}, {31'd0, er});
            check({name, ".resp"},  {31'd0, bus.HRESP},     {31'd0, eresp});
            check({name, ".rdata"}, bus.HRDATA, edata);
            if (pend && er && !perr) begin
                if (p.wr) model_write(p);
                else rd_log.push_back(bus.HRDATA);
            end
            @(posedge HCLK); #1;
            if (pend) begin
                if (er) pend = 0; else ph++;
            end
            if (er && i < q.size()) begin
                if (q[i].sel && q[i].trans[1]) begin
                    p = q[i]; pend = 1; ph = 0; perr = model_err(q[i]);
                end
                i++;
            end
        end
        check({name, ".done"}, 32'(q.size() - i) + {31'd0, pend}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t q[$];
        beat_t b;
        int    r;

        HRESET = 1'b1;
        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HWRITE = 1'b0; bus.HTRANS = 2'b00;
        bus.HSIZE = 3'b010; bus.HBURST = 3'b000; bus.HWDATA = '0;
        repeat (2) @(posedge HCLK);
        #1;
        check("reset.rdy",   {31'd0, bus.HREADYOUT}, 32'd1);
        check("reset.resp",  {31'd0, bus.HRESP},     32'd0);
        check("reset.rdata", bus.HRDATA,             32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        // Fill the whole array with zeros so every read has a known answer
        q.delete();
        for (int k = 0; k < 256; k++) q.push_back(mk(1, 32'(k*4), 3'd2, 32'd0, (k == 0) ? 2'b10 : 2'b11, 1));
        run_beats("init", q);

        // Reset in the middle of a write data phase must drop the write
        drive_addr(mk(1, 32'h10, 3'd2, 32'h0, 2'b10, 1));
        @(posedge HCLK); #1;
        drive_idle();
        bus.HWDATA = 32'hDEADBEEF;
        #3 HRESET = 1'b1;
        #1;
        check("rst_mid.rdy",   {31'd0, bus.HREADYOUT}, 32'd1);
        check("rst_mid.resp",  {31'd0, bus.HRESP},     32'd0);
        check("rst_mid.rdata", bus.HRDATA,             32'd0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        rd_log.delete();
        q.delete();
        q.push_back(mk(0, 32'h10, 3'd2, 32'h0, 2'b10, 1));
        run_beats("rst_rd", q);
        check("rst_rd.n", 32'(rd_log.size()), 32'd1);
        check("rst_rd.nocommit", {31'd0, rd_log[0] == 32'hDEADBEEF}, 32'd0);

        // Word write then immediate read of the same address
        rd_log.delete();
        q.delete();
        q.push_back(mk(1, 32'h20, 3'd2, 32'hA5A51234, 2'b10, 1));
        q.push_back(mk(0, 32'h20, 3'd2, 32'h0, 2'b10, 1));
        run_beats("word", q);
        check("word.val", rd_log[0], 32'hA5A51234);

        // Byte and halfword lanes; junk on unused lanes must not land
        rd_log.delete();
        q.delete();
        q.push_back(mk(1, 32'h40, 3'd2, 32'h0, 2'b10, 1));
        q.push_back(mk(1, 32'h42, 3'd0, 32'h11EE2233, 2'b10, 1));
        q.push_back(mk(1, 32'h40, 3'd1, 32'h4455BEEF, 2'b10, 1));
        q.push_back(mk(0, 32'h40, 3'd2, 32'h0, 2'b10, 1));
        run_beats("lanes", q);
        check("lanes.val", rd_log[0], 32'h00EEBEEF);

        // Four-beat write burst followed directly by a read burst
        rd_log.delete();
        q.delete();
        for (int k = 0; k < 4; k++) q.push_back(mk(1, 32'(32'h80 + k*4), 3'd2, 32'(k+1), (k == 0) ? 2'b10 : 2'b11, 1));
        for (int k = 0; k < 4; k++) q.push_back(mk(0, 32'(32'h80 + k*4), 3'd2, 32'h0, (k == 0) ? 2'b10 : 2'b11, 1));
        run_beats("burst", q);
        check("burst.n", 32'(rd_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) check("burst.val", rd_log[k], 32'(k+1));

        // Error responses leave memory untouched
        rd_log.delete();
        q.delete();
        q.push_back(mk(1, 32'h0, 3'd2, 32'h0BADF00D, 2'b10, 1));
        q.push_back(mk(0, 32'h401, 3'd2, 32'h0, 2'b10, 1));
        q.push_back(mk(0, 32'h3, 3'd1, 32'h0, 2'b10, 1));
        q.push_back(mk(1, 32'h3, 3'd1, 32'hFFFFFFFF, 2'b10, 1));
        q.push_back(mk(1, 32'h2, 3'd2, 32'hFFFFFFFF, 2'b10, 1));
        q.push_back(mk(1, 32'h0, 3'd3, 32'hFFFFFFFF, 2'b10, 1));
        q.push_back(mk(0, 32'h0, 3'd2, 32'h0, 2'b10, 1));
        run_beats("err", q);
        check("err.n", 32'(rd_log.size()), 32'd1);
        check("err.val", rd_log[0], 32'h0BADF00D);

        // BUSY inside a burst and a deselected beat are zero-wait OKAY
        rd_log.delete();
        q.delete();
        q.push_back(mk(1, 32'h100, 3'd2, 32'h01020304, 2'b10, 1));
        q.push_back(mk(1, 32'h104, 3'd2, 32'h0, 2'b01, 1));
        q.push_back(mk(1, 32'h104, 3'd2, 32'h05060708, 2'b11, 1));
        q.push_back(mk(1, 32'h104, 3'd2, 32'hFFFFFFFF, 2'b10, 0));
        q.push_back(mk(0, 32'h104, 3'd2, 32'h0, 2'b10, 1));
        run_beats("busy", q);
        check("busy.val", rd_log[0], 32'h05060708);

        // Randomized traffic against the byte-level model
        q.delete();
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            b.trans = (r < 40) ? 2'b10 : (r < 70) ? 2'b11 : (r < 85) ? 2'b00 : 2'b01;
            b.sel   = ($urandom_range(0, 9) != 0);
            b.wr    = $urandom_range(0, 1) == 1;
            b.data  = $urandom;
            b.size  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            b.addr  = ($urandom_range(0, 19) == 0) ? 32'(1024 + $urandom_range(0, 4095)) : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 4) != 0 && b.size <= 3'd2 && b.addr < 32'd1024)
                b.addr = b.addr & ~((32'd1 << b.size) - 32'd1);
            q.push_back(b);
        end
        run_beats("rand", q);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB-Lite slave wrapping a word-organised on-chip SRAM. It is the DUT consumed by the AHB slave verification environment: the driver feeds its bus inputs, and the monitor and reference model observe its responses. It implements pipelined address and data phases, little-endian byte lanes, an OKAY/ERROR response FSM and optional programmable wait states.

Parameters:
ADDR_W, 32, HADDR width.
MEM_DEPTH, 256, number of 32-bit words; valid byte address range is 0 to MEM_DEPTH*4-1.
WAIT_CYCLES, 2, HREADYOUT-low cycles per data phase; used only with AHB_WAIT_STATE_EN; legal range 0-15.

Ports:
HCLK  in  1  bus clock; all state updates on the rising edge.
HRESET  in  1  asynchronous reset, active-high.
HSEL  in  1  slave select.
HADDR  in  ADDR_W  byte address.
HWRITE  in  1  1 = write, 0 = read.
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
HSIZE  in  3  000 byte, 001 halfword, 010 word; other values are illegal.
HBURST  in  3  accepted and ignored; each beat is decoded independently.
HWDATA  in  32  write data, sampled in the data phase.
HREADY  in  1  bus-level ready from the interconnect mux.
HREADYOUT  out  1  slave ready.
HRESP  out  1  0 OKAY, 1 ERROR.
HRDATA  out  32  read data.

Behaviour:
- Reset (async, HRESET=1): FSM=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, all phase registers cleared, wait counter=0. Memory contents are not reset.
- Reset asserted mid-transfer aborts it; a pending write is not committed.
- Address phase accepted on a rising edge with HSEL & HREADY & HTRANS[1]. On accept, register addr_q, write_q, size_q and err_q.
- err_q is set when any of the following holds:
  - HADDR >= MEM_DEPTH*4;
  - HSIZE > 010;
  - misalignment: halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
- IDLE/BUSY, or HSEL=0, while HREADY=1: no access; next cycle is zero-wait OKAY.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. Accepted transfer goes to DATA, or to ERR1 if err_q.
  - DATA: HREADYOUT=1, HRESP=0. Write: on the edge ending this cycle, write HWDATA lanes into mem[addr_q[..:2]]. Read: HRDATA = mem[addr_q[..:2]] (full word; master selects lanes). Exits to DATA, ERR1 or IDLE according to the address phase sampled on the same edge (pipelining, no bubble).
  - WAIT (feature only): see Optional Feature.
  - ERR1: HREADYOUT=0, HRESP=1, no memory access. Goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Address phase sampled here is accepted normally; a master IDLE here returns the slave to IDLE.
- Byte-lane enables (little-endian):
  - byte: lane HADDR[1:0];
  - halfword: lanes {HADDR[1],0} and {HADDR[1],1};
  - word: all four lanes.
- HRDATA is 0 in any cycle that is not a read data phase.
- Write-then-read to the same address back-to-back: the read returns the new data (the write commits on the edge that starts the read data phase).
- Back-to-back NONSEQ/SEQ beats sustain 1 transfer/cycle with no wait states.

Optional Feature:
AHB_WAIT_STATE_EN
- Defined: an accepted non-error transfer enters WAIT for WAIT_CYCLES cycles with HREADYOUT=0 and HRESP=0, a counter counting down, then DATA. The write commits, and read data is valid, only in DATA. Address phases are not accepted while HREADY=0. WAIT_CYCLES=0 behaves as zero-wait. Error transfers skip WAIT.
- Undefined: WAIT state and counter are absent; all OKAY transfers are zero-wait.

Test Plan:
- Reset check: HRESET=1 mid-write of 0xDEADBEEF to 0x10 -> outputs HREADYOUT=1/HRESP=0/HRDATA=0; a subsequent read of 0x10 does not return 0xDEADBEEF.
- Word write/read: NONSEQ write 0xA5A5_1234 @0x20, then read @0x20 -> HRDATA=0xA5A5_1234, HRESP=0, zero wait.
- Byte lanes: word 0x0 @0x40; byte write 0xEE @0x42; halfword write 0xBEEF @0x40; read @0x40 -> 0x00EE_BEEF.
- Back-to-back: 4-beat INCR write @0x80..0x8C with data 1..4, then an immediate read burst -> 1,2,3,4 returned with HREADYOUT continuously 1.
- Errors: word read @0x401 (MEM_DEPTH=256) -> HREADYOUT 0 then 1 with HRESP=1 for both cycles, memory unchanged; halfword @0x3 -> same two-cycle ERROR.
- With AHB_WAIT_STATE_EN and WAIT_CYCLES=2: write @0x0 -> HREADYOUT low exactly 2 cycles, write commits after; a BUSY transfer during the burst -> zero-wait OKAY.
